// File: rtl/credit_rx_port.sv
// credit_rx_port
//   Receive end of the PE-to-router credit link. Incoming flits are buffered
//   in a DEPTH-entry FIFO and presented first-word-fall-through to the
//   crossbar. Every flit the crossbar consumes returns one registered credit
//   pulse on co, so a sender that starts with DEPTH credits can never overrun
//   the buffer.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   RST          synchronous active-high reset
//   datain       flit from sender
//   in_valid     datain carries a flit this cycle
//   dataout      head flit, forced to zero while empty
//   out_valid    FIFO non-empty
//   out_ready    crossbar consumes the head flit this cycle
//   co           credit return pulse, one cycle per consumed flit
//   occupancy    number of stored flits, 0..DEPTH
//   overflow_err sticky: flit arrived while full with no simultaneous pop
module credit_rx_port #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [DATA_W-1:0] datain,
  input  logic              in_valid,
  output logic [DATA_W-1:0] dataout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              co,
  output logic [CNT_W-1:0]  occupancy,
  output logic              overflow_err
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              pop;
  logic              push;

  assign full = (count == CNT_W'(DEPTH));
  assign pop  = out_valid & out_ready;
  // A pop in the same edge frees a slot, so a full FIFO may still accept.
  assign push = in_valid & (~full | pop);

  assign out_valid = (count != '0);
  assign dataout   = out_valid ? mem[rd_ptr] : '0;
  assign occupancy = count;

  // Storage needs no reset: reads are masked while empty.
  always_ff @(posedge clk) begin
    if (!RST && push) begin
      mem[wr_ptr] <= datain;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      co           <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      co <= pop;
      if (in_valid && full && !pop) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule
